// File: rtl/fe_rr_fifo_32_to_8.sv
// fe_rr_fifo_32_to_8
// Merges NCH first-word-fall-through receiver FIFOs into a single byte stream.
// A round-robin arbiter moves one 32-bit word per cycle into a circular word
// buffer, and a serialiser emits each buffered word as four bytes.

`timescale 1ns/1ps

module fe_rr_fifo_32_to_8 #(
  parameter int NCH       = 4,
  parameter int DEPTH     = 1024,
  parameter bit MSB_FIRST = 1'b0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST_N,
  input  logic [NCH-1:0]    CH_EMPTY,
  input  logic [32*NCH-1:0] CH_DATA,
  output logic [NCH-1:0]    CH_READ,
  input  logic [NCH-1:0]    CH_ENABLE,
  input  logic              TX_FULL,
  output logic              TX_WR,
  output logic [7:0]        TX_DATA,
  output logic              FIFO_EMPTY,
  output logic              FIFO_FULL,
  output logic [CW-1:0]     WORD_COUNT,
  output logic [GW-1:0]     GRANT_CH
);

  // Channel index base+offset, wrapped into 0..NCH-1 (offset is at most NCH).
  function automatic logic [GW-1:0] rrIndex(input logic [GW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NCH) sum = sum - NCH;
    return GW'(sum);
  endfunction

  logic [31:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [GW-1:0]  r_rr_ptr;
  logic [GW-1:0]  r_grant_ch;
  logic [31:0]    r_ser_word;
  logic [1:0]     r_ser_idx;
  logic           r_ser_valid;
  logic           r_run;

  logic [NCH-1:0] w_req;
  logic           w_found;
  logic [GW-1:0]  w_winner;
  logic           w_grant;
  logic [31:0]    w_wr_data;
  logic           w_load;
  logic           w_rd;
  logic [1:0]     w_byte_sel;

  assign w_req = ~CH_EMPTY & CH_ENABLE;

  // Cyclic search for the first requesting channel at or after the RR pointer.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && w_req[rrIndex(r_rr_ptr, i)]) begin
        w_found  = 1'b1;
        w_winner = rrIndex(r_rr_ptr, i);
      end
    end
  end

  // r_run keeps CH_READ low while reset is held and until the first clock after release,
  // so no source FIFO is popped while the buffer cannot accept the word.
  assign FIFO_FULL = (r_count == CW'(DEPTH));
  assign w_grant   = w_found & ~FIFO_FULL & r_run;

  // One-hot pop strobe and data mux for the winning channel.
  always_comb begin
    CH_READ   = '0;
    w_wr_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_grant && (int'(w_winner) == k)) begin
        CH_READ[k] = 1'b1;
        w_wr_data  = CH_DATA[32*k +: 32];
      end
    end
  end

  // The serialiser takes a new word when idle or while sending the last byte of the current one.
  assign TX_WR      = r_ser_valid & ~TX_FULL;
  assign w_load     = ~r_ser_valid | (TX_WR & (r_ser_idx == 2'd3));
  assign w_rd       = w_load & (r_count != '0);
  assign FIFO_EMPTY = (r_count == '0) & ~r_ser_valid;
  assign WORD_COUNT = r_count;
  assign GRANT_CH   = r_grant_ch;

  // Byte lane select for the current serialiser position and byte order.
  always_comb begin
    w_byte_sel = MSB_FIRST ? (2'd3 - r_ser_idx) : r_ser_idx;
    case (w_byte_sel)
      2'd0:    TX_DATA = r_ser_word[7:0];
      2'd1:    TX_DATA = r_ser_word[15:8];
      2'd2:    TX_DATA = r_ser_word[23:16];
      default: TX_DATA = r_ser_word[31:24];
    endcase
  end

  // Release flag: arbitration starts on the first clock after reset deasserts.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) r_run <= 1'b0;
    else            r_run <= 1'b1;
  end

  // Word storage; contents need no reset because the pointers and count define validity.
  always_ff @(posedge BUS_CLK) begin
    if (w_grant) r_mem[r_wr_ptr] <= w_wr_data;
  end

  // Circular buffer pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_grant) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_grant, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Round-robin pointer moves past the winner on each grant and holds otherwise.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_rr_ptr   <= '0;
      r_grant_ch <= '0;
    end else if (w_grant) begin
      r_rr_ptr   <= rrIndex(w_winner, 1);
      r_grant_ch <= w_winner;
    end
  end

  // Serialiser: load the next buffered word, advance the byte index, or hold under TX_FULL.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_ser_word  <= '0;
      r_ser_idx   <= '0;
      r_ser_valid <= 1'b0;
    end else if (w_load) begin
      if (w_rd) begin
        r_ser_word  <= r_mem[r_rd_ptr];
        r_ser_idx   <= 2'd0;
        r_ser_valid <= 1'b1;
      end else begin
        r_ser_valid <= 1'b0;
      end
    end else if (TX_WR) begin
      r_ser_idx <= r_ser_idx + 2'd1;
    end
  end

endmodule
